spi_peripheral: RTL and testbench

Write-only SPI Mode-0 slave that sits directly upstream of the PWM generator inside tt_um_uwasic_samanyu_shrivastava.
- Receives 16-bit frames from an external controller on ui_in pins.
- Decodes address/data and updates five 8-bit control registers.
- The PWM stage consumes those registers directly.
- All SPI inputs are asynchronous to clk and are synchronised inside this block.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/sync_edge.sv | 35 +++
 rtl/spi_peripheral.sv | 119 +++++++++++
 tb/tb_spi_peripheral.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared register map, frame length and FSM state encoding for the SPI peripheral.
`default_nettype none

package spi_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser for one asynchronous input, with level, rise and fall outputs.
`default_nettype none

module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
      prev   <= RESET_VAL;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      prev   <= stages[SYNC_STAGES-1];
    end
  end

  assign level = stages[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

`default_nettype wire

// File: rtl/spi_peripheral.sv
// spi_peripheral: write-only SPI mode-0 slave that loads five 8-bit PWM control registers
// from 16-bit {write, addr[6:0], data[7:0]} frames.
`default_nettype none

module spi_peripheral
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
  localparam logic [4:0] SAT_CNT   = FRAME_CNT + 5'd1;

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level,  ncs_rise,  ncs_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  // Chip select idles high, so its chain resets to 1 to avoid a false fall after reset.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_level, sclk_fall, copi_rise, copi_fall, ncs_level};

  state_t                  state;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [4:0]              bit_cnt;

  logic       frame_ok;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;

  assign frame_addr = shift_reg[14:8];
  assign frame_data = shift_reg[7:0];
  assign frame_ok   = (bit_cnt == FRAME_CNT) && shift_reg[15] && (frame_addr <= MAX_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      wr_strobe       <= 1'b0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (sclk_rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_level};
            // Saturate one past a full frame so overlong frames stay distinguishable.
            if (bit_cnt != SAT_CNT) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          if (ncs_rise) begin
            state <= COMMIT;
          end
        end

        COMMIT: begin
          if (frame_ok) begin
            wr_strobe <= 1'b1;
            case (frame_addr)
              ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= frame_data;
              ADDR_EN_OUT_15_8: en_reg_out_15_8 <= frame_data;
              ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= frame_data;
              ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= frame_data;
              ADDR_PWM_DUTY:    pwm_duty_cycle  <= frame_data;
              default: ;
            endcase
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed frames driven at sclk = clk/4 with hand-computed register expectations.
`default_nettype none

module tb_spi_peripheral;

  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 2;
  localparam int NOSTB = -1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       wr_strobe;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int lat;
  int snap;

  spi_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .wr_strobe(wr_strobe)
  );

  always #50 clk = ~clk;

  always @(posedge clk) if (wr_strobe) strobe_cnt = strobe_cnt + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the low nbits of frame MSB first, then holds ncs high for gap clocks
  // and reports the clk index (1-based) where wr_strobe was first seen, or -1.
  task automatic send_frame(input logic [31:0] frame, input int nbits, input int gap,
                            output int strobe_at);
    ncs = 1'b0;
    wait_clk(2);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = frame[i];
      wait_clk(2);
      sclk = 1'b1;
      wait_clk(2);
      sclk = 1'b0;
    end
    wait_clk(2);
    ncs = 1'b1;
    strobe_at = NOSTB;
    for (int k = 1; k <= gap; k++) begin
      @(negedge clk);
      if (wr_strobe && strobe_at == NOSTB) strobe_at = k;
    end
  endtask

  task automatic check_regs(input string tag, input int e0, input int e1, input int e2,
                            input int e3, input int e4);
    check({tag, ".r0"}, int'(r0), e0);
    check({tag, ".r1"}, int'(r1), e1);
    check({tag, ".r2"}, int'(r2), e2);
    check({tag, ".r3"}, int'(r3), e3);
    check({tag, ".r4"}, int'(r4), e4);
  endtask

  initial begin
    wait_clk(3);
    check_regs("reset", 0, 0, 0, 0, 0);
    check("reset.strobe", int'(wr_strobe), 0);
    rst = 1'b0;
    wait_clk(3);

    send_frame(32'h8233, 16, 6, lat);
    check("pre.r2", int'(r2), 8'h33);
    check("pre.lat", lat, LAT);

    // Abort a frame half way with reset; ncs returns high while reset is held.
    ncs = 1'b0;
    wait_clk(2);
    for (int i = 0; i < 8; i++) begin
      copi = i[0];
      wait_clk(2);
      sclk = 1'b1;
      wait_clk(2);
      sclk = 1'b0;
    end
    rst = 1'b1;
    ncs = 1'b1;
    wait_clk(2);
    check_regs("midrst", 0, 0, 0, 0, 0);
    check("midrst.strobe", int'(wr_strobe), 0);
    rst = 1'b0;
    wait_clk(4);
    send_frame(32'h8055, 16, 6, lat);
    check("postrst.r0", int'(r0), 8'h55);

    snap = strobe_cnt;
    send_frame(32'h80F0, 16, 6, lat);
    send_frame(32'h81A5, 16, 6, lat);
    send_frame(32'h82FF, 16, 6, lat);
    send_frame(32'h8301, 16, 6, lat);
    send_frame(32'h8480, 16, 6, lat);
    check_regs("all", 8'hF0, 8'hA5, 8'hFF, 8'h01, 8'h80);
    check("all.strobes", strobe_cnt - snap, 5);

    send_frame(32'h8433, 16, 6, lat);
    check("duty.r4", int'(r4), 8'h33);
    snap = strobe_cnt;
    send_frame(32'h8599, 16, 6, lat);
    check("badaddr.lat", lat, NOSTB);
    send_frame(32'h0477, 16, 6, lat);
    check("read.lat", lat, NOSTB);
    check_regs("drop", 8'hF0, 8'hA5, 8'hFF, 8'h01, 8'h33);
    check("drop.strobes", strobe_cnt - snap, 0);

    send_frame(32'h4155, 15, 6, lat);
    check("short.r2", int'(r2), 8'hFF);
    check("short.lat", lat, NOSTB);
    send_frame(32'h10555, 17, 6, lat);
    check("long.r2", int'(r2), 8'hFF);
    check("long.lat", lat, NOSTB);

    send_frame(32'h8011, 16, LAT, lat);
    check("b2b1.lat", lat, LAT);
    check("b2b1.r0", int'(r0), 8'h11);
    send_frame(32'h8022, 16, 6, lat);
    check("b2b2.lat", lat, LAT);
    check("b2b2.r0", int'(r0), 8'h22);

    snap = strobe_cnt;
    for (int i = 0; i < 6; i++) begin
      copi = ~copi;
      sclk = 1'b1;
      wait_clk(2);
      sclk = 1'b0;
      wait_clk(2);
    end
    send_frame(32'h8177, 16, 6, lat);
    check_regs("noise", 8'h22, 8'h77, 8'hFF, 8'h01, 8'h33);
    check("noise.strobes", strobe_cnt - snap, 1);

    wait_clk(20);
    check_regs("hold", 8'h22, 8'h77, 8'hFF, 8'h01, 8'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
